// File: rtl/debounce_multi.sv
// debounce_multi: NCH independent active-low key debouncers sharing one sample tick.
// Optional auto-repeat of key_press is compiled in with DEBOUNCE_REPEAT_EN.
module debounce_multi #(
  parameter int NCH        = 4,
  parameter int STABLE_CNT = 2048
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 50000,
  parameter int REPEAT_PER = 10000
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [NCH-1:0] key,
  output logic [NCH-1:0] key_stable,
  output logic [NCH-1:0] key_press,
  output logic [NCH-1:0] key_release,
  output logic           any_pressed
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   stable_q, stable_d;
  logic [NCH-1:0]   press_q, press_d;
  logic [NCH-1:0]   release_q, release_d;
  logic             any_q, any_d;
  logic [NCH-1:0]   fall_evt, rise_evt;
  logic [NCH-1:0]   rpt_fire;

  // Any synchroniser disagreement restarts the count, even while tick is low.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync1_q[i] != sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] < CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stable_d = stable_q;
    fall_evt = '0;
    rise_evt = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((cnt_q[i] == CNT_MAX) && (sync2_q[i] != stable_q[i])) begin
        stable_d[i] = sync2_q[i];
        if (sync2_q[i]) begin
          rise_evt[i] = 1'b1;
        end else begin
          fall_evt[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_d   = fall_evt | rpt_fire;
    release_d = rise_evt;
    any_d     = |(~stable_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '1;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= key;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q [NCH];
  logic [RPT_W-1:0] rpt_d [NCH];
  logic [NCH-1:0]   rpt_first_q, rpt_first_d;
  logic [RPT_W-1:0] rpt_target;

  // The first repeat waits REPEAT_DLY ticks, later ones REPEAT_PER; a pending
  // release wins so press and release never coincide.
  always_comb begin
    rpt_first_d = rpt_first_q;
    rpt_fire    = '0;
    rpt_target  = '0;
    for (int i = 0; i < NCH; i++) begin
      rpt_d[i]   = rpt_q[i];
      rpt_target = rpt_first_q[i] ? RPT_W'(REPEAT_PER) : RPT_W'(REPEAT_DLY);
      if (stable_q[i] || rise_evt[i]) begin
        rpt_d[i]       = '0;
        rpt_first_d[i] = 1'b0;
      end else if (tick) begin
        if ((rpt_q[i] + RPT_W'(1)) == rpt_target) begin
          rpt_fire[i]    = 1'b1;
          rpt_d[i]       = '0;
          rpt_first_d[i] = 1'b1;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_first_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < NCH; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  assign key_stable  = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_pressed = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: the driver pushes expected pulses and level
// snapshots tagged with their cycle; a negedge monitor pops and compares them.
module tb_debounce_multi;

  localparam int SC = 4;
  localparam int W  = 45;  // {cyc[31:0], press[3:0], release[3:0], stable[3:0], any}

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] key;
  logic [3:0] key_stable, key_press, key_release;
  logic       any_pressed;
  logic [31:0] cyc = '0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] lvl_q[$];
  logic [W-1:0] rpt_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  logic done = 1'b0;
  logic done_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  debounce_multi #(.NCH(4), .STABLE_CNT(SC)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key),
    .key_stable(key_stable), .key_press(key_press),
    .key_release(key_release), .any_pressed(any_pressed)
  );

`ifdef DEBOUNCE_REPEAT_EN
  logic [3:0] kr;
  logic [3:0] r_stable, r_press, r_release;
  logic       r_any;
  debounce_multi #(.NCH(4), .STABLE_CNT(2), .REPEAT_DLY(8), .REPEAT_PER(3)) u_rpt (
    .clk(clk), .rst(rst), .tick(tick), .key(kr),
    .key_stable(r_stable), .key_press(r_press),
    .key_release(r_release), .any_pressed(r_any)
  );
`endif

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {cyc, key_press, key_release, key_stable, any_pressed};
    if ((key_press != 4'h0) || (key_release != 4'h0)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected cyc=%0d got press=%h rel=%h stable=%h any=%b",
                 cyc, key_press, key_release, key_stable, any_pressed);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL pulse got cyc=%0d p=%h r=%h s=%h a=%b, expected cyc=%0d p=%h r=%h s=%h a=%b",
                   got[44:13], got[12:9], got[8:5], got[4:1], got[0],
                   exp[44:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
      end
    end
    if ((lvl_q.size() != 0) && (lvl_q[0][44:13] == cyc)) begin
      exp = lvl_q.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL level cyc=%0d got p=%h r=%h s=%h a=%b, expected p=%h r=%h s=%h a=%b",
                 cyc, got[12:9], got[8:5], got[4:1], got[0],
                 exp[12:9], exp[8:5], exp[4:1], exp[0]);
      end
    end
`ifdef DEBOUNCE_REPEAT_EN
    if ((r_press != 4'h0) || (r_release != 4'h0)) begin
      got = {cyc, r_press, r_release, r_stable, r_any};
      n_vec++;
      if (rpt_q.size() == 0) begin
        n_fail++;
        $display("FAIL repeat_unexpected cyc=%0d got p=%h r=%h s=%h", cyc, r_press, r_release, r_stable);
      end else begin
        exp = rpt_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL repeat got cyc=%0d p=%h r=%h s=%h a=%b, expected cyc=%0d p=%h r=%h s=%h a=%b",
                   got[44:13], got[12:9], got[8:5], got[4:1], got[0],
                   exp[44:13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
        end
      end
    end
`endif
    if (done && !done_chk) begin
      done_chk = 1'b1;
      n_vec++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL pulse_missing left=%0d next_cyc=%0d", exp_q.size(), exp_q[0][44:13]);
      end
      n_vec++;
      if (lvl_q.size() != 0) begin
        n_fail++;
        $display("FAIL level_missing left=%0d", lvl_q.size());
      end
      n_vec++;
      if (rpt_q.size() != 0) begin
        n_fail++;
        $display("FAIL repeat_missing left=%0d next_cyc=%0d", rpt_q.size(), rpt_q[0][44:13]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_evt(input logic [31:0] at, input logic [3:0] pr, input logic [3:0] rl,
                          input logic [3:0] st);
    exp_q.push_back({at, pr, rl, st, ~&st});
  endtask

  task automatic push_lvl(input logic [31:0] at, input logic [3:0] st);
    lvl_q.push_back({at, 4'h0, 4'h0, st, ~&st});
  endtask

  task automatic push_rpt(input logic [31:0] at, input logic [3:0] pr, input logic [3:0] rl,
                          input logic [3:0] st);
    rpt_q.push_back({at, pr, rl, st, ~&st});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c;
    rst  = 1'b0;
    tick = 1'b1;
    key  = 4'hF;
`ifdef DEBOUNCE_REPEAT_EN
    kr   = 4'hF;
`endif
    push_lvl(32'd2, 4'hF);
    step(2);
    rst = 1'b1;
    step(8);

    // clean press and release on channel 0
    c = cyc; key = 4'hE;
    push_lvl(c + SC + 2, 4'hF);
    push_evt(c + SC + 3, 4'h1, 4'h0, 4'hE);
    push_lvl(c + SC + 4, 4'hE);
    step(12);
    c = cyc; key = 4'hF;
    push_evt(c + SC + 3, 4'h0, 4'h1, 4'hF);
    step(12);

    // channel 1 bounces every 3 cycles, then settles low
    for (int s = 0; s < 10; s++) begin
      key[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    c = cyc; key[1] = 1'b0;
    push_evt(c + SC + 3, 4'h2, 4'h0, 4'hD);
    step(12);
    c = cyc; key[1] = 1'b1;
    push_evt(c + SC + 3, 4'h0, 4'h2, 4'hF);
    step(12);

    // channel 2 with tick on every 4th clock: count advances on edges c+4,8,12,16
    c = cyc; key[2] = 1'b0;
    push_lvl(c + 16, 4'hF);
    push_evt(c + 4 * SC + 1, 4'h4, 4'h0, 4'hB);
    for (int p = 0; p < 20; p++) begin
      tick = (p % 4 == 3);
      step(1);
    end
    tick = 1'b1;
    c = cyc; key[2] = 1'b1;
    push_evt(c + SC + 3, 4'h0, 4'h4, 4'hF);
    step(12);

    // channel 3 held low with tick frozen, then tick resumes
    c = cyc; tick = 1'b0; key[3] = 1'b0;
    push_lvl(c + 29, 4'hF);
    step(30);
    c = cyc; tick = 1'b1;
    push_evt(c + SC + 1, 4'h8, 4'h0, 4'h7);
    step(10);
    c = cyc; key[3] = 1'b1;
    push_evt(c + SC + 3, 4'h0, 4'h8, 4'hF);
    step(12);

    // all channels together
    c = cyc; key = 4'h0;
    push_evt(c + SC + 3, 4'hF, 4'h0, 4'h0);
    step(12);
    c = cyc; key = 4'hF;
    push_evt(c + SC + 3, 4'h0, 4'hF, 4'hF);
    step(12);

    // reset two edges before saturation; keys stay low through release
    c = cyc; key = 4'h0;
    step(3);
    rst = 1'b0;
    push_lvl(c + 5, 4'hF);
    step(2);
    c = cyc; rst = 1'b1;
    push_evt(c + SC + 3, 4'hF, 4'h0, 4'h0);
    step(12);
    c = cyc; key = 4'hF;
    push_evt(c + SC + 3, 4'h0, 4'hF, 4'hF);
    step(12);

`ifdef DEBOUNCE_REPEAT_EN
    // STABLE_CNT=2: press at +5, repeats 8 then every 3 ticks; the one due with
    // the release commit is suppressed
    c = cyc; kr = 4'hE;
    push_rpt(c + 5,  4'h1, 4'h0, 4'hE);
    push_rpt(c + 13, 4'h1, 4'h0, 4'hE);
    push_rpt(c + 16, 4'h1, 4'h0, 4'hE);
    push_rpt(c + 19, 4'h1, 4'h0, 4'hE);
    push_rpt(c + 22, 4'h1, 4'h0, 4'hE);
    step(20);
    c = cyc; kr = 4'hF;
    push_rpt(c + 5, 4'h0, 4'h1, 4'hF);
    step(20);
`endif

    done = 1'b1;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
